// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command-side initiator for a combinational ALU. Takes one command at a
//   time, reads operands from a 4 x 8-bit register file, drives the ALU ports
//   for a single EXEC cycle, writes the result back (unless nowb), updates the
//   {N,Z,C,V} status register and returns result + flags on a response
//   handshake.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cmd_*                 command handshake and fields (cmd_ready high in IDLE)
//   alu_operation/operand ALU drive, registered from the accepted command
//   alu_result/alu_*flag  ALU outputs, sampled only at the end of EXEC
//   rsp_valid/ready/data/flags  response handshake; flags = {N,Z,C,V}
//   dbg_addr/dbg_data     combinational register-file read port
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | ready for a command; accepting one latches it and the operands
// ST_EXEC   | ALU ports valid; result, flags and writeback taken at the edge
// ST_RESP   | response held stable until rsp_ready
module alu_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [1:0] cmd_rd,
   input  logic [1:0] cmd_rs,
   input  logic       cmd_use_imm,
   input  logic [7:0] cmd_imm,
   input  logic       cmd_nowb,
   output logic [3:0] alu_operation,
   output logic [7:0] alu_operand1,
   output logic [7:0] alu_operand2,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   input  logic       alu_overflow,
   input  logic       alu_carry,
   input  logic       alu_negative,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [3:0] rsp_flags,
   input  logic [1:0] dbg_addr,
   output logic [7:0] dbg_data
);

   localparam int REG_COUNT = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0] state_q, state_d;
   logic [1:0] cmd_rd_q, cmd_rd_d;
   logic       cmd_nowb_q, cmd_nowb_d;
   logic [3:0] alu_op_q, alu_op_d;
   logic [7:0] alu_opnd1_q, alu_opnd1_d;
   logic [7:0] alu_opnd2_q, alu_opnd2_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic [3:0] flags_q, flags_d;
   logic [7:0] regs_q [REG_COUNT];
   logic [7:0] regs_d [REG_COUNT];

   always_comb begin
      state_d     = state_q;
      cmd_rd_d    = cmd_rd_q;
      cmd_nowb_d  = cmd_nowb_q;
      alu_op_d    = alu_op_q;
      alu_opnd1_d = alu_opnd1_q;
      alu_opnd2_d = alu_opnd2_q;
      rsp_data_d  = rsp_data_q;
      flags_d     = flags_q;
      regs_d      = regs_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d    = ST_EXEC;
               cmd_rd_d   = cmd_rd;
               cmd_nowb_d = cmd_nowb;
               // Operands are read here, one cycle before EXEC, so the ALU
               // ports are already registered when EXEC begins. No write can
               // be pending in IDLE, so this read is never stale.
               alu_op_d    = cmd_op;
               alu_opnd1_d = regs_q[cmd_rd];
               alu_opnd2_d = cmd_use_imm ? cmd_imm : regs_q[cmd_rs];
            end
         end
         ST_EXEC: begin
            state_d    = ST_RESP;
            rsp_data_d = alu_result;
            flags_d    = {alu_negative, alu_zero, alu_carry, alu_overflow};
            if (!cmd_nowb_q) begin
               regs_d[cmd_rd_q] = alu_result;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_rd_q    <= 2'd0;
         cmd_nowb_q  <= 1'b0;
         alu_op_q    <= 4'd0;
         alu_opnd1_q <= 8'd0;
         alu_opnd2_q <= 8'd0;
         rsp_data_q  <= 8'd0;
         flags_q     <= 4'd0;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= 8'd0;
         end
      end else begin
         state_q     <= state_d;
         cmd_rd_q    <= cmd_rd_d;
         cmd_nowb_q  <= cmd_nowb_d;
         alu_op_q    <= alu_op_d;
         alu_opnd1_q <= alu_opnd1_d;
         alu_opnd2_q <= alu_opnd2_d;
         rsp_data_q  <= rsp_data_d;
         flags_q     <= flags_d;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign rsp_valid     = (state_q == ST_RESP);
   assign rsp_data      = rsp_data_q;
   assign rsp_flags     = flags_q;
   assign alu_operation = alu_op_q;
   assign alu_operand1  = alu_opnd1_q;
   assign alu_operand2  = alu_opnd2_q;
   assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU attached to the
// ALU ports. Expected responses are computed from a bench-side register-file
// model and queued at command acceptance, then popped at the response.
module tb_alu_sequencer;

   // Op codes understood by the bench ALU model; the sequencer passes them
   // through untouched.
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_SHL = 4'h5;
   localparam logic [3:0] OP_SHR = 4'h6;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready;
   logic [3:0] cmd_op;
   logic [1:0] cmd_rd, cmd_rs;
   logic       cmd_use_imm, cmd_nowb;
   logic [7:0] cmd_imm;
   logic [3:0] alu_operation;
   logic [7:0] alu_operand1, alu_operand2, alu_result;
   logic       alu_zero, alu_overflow, alu_carry, alu_negative;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic [3:0] rsp_flags;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] flags;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model [4];
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_use_imm(cmd_use_imm),
      .cmd_imm(cmd_imm), .cmd_nowb(cmd_nowb),
      .alu_operation(alu_operation), .alu_operand1(alu_operand1),
      .alu_operand2(alu_operand2), .alu_result(alu_result),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .alu_carry(alu_carry), .alu_negative(alu_negative),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_flags(rsp_flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Returns {result, N, Z, C, V}. C is "no borrow" for SUB; logic and
   // shift ops clear C and V.
   function automatic logic [11:0] alu_f(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] r;
      logic       c, v;
      c = 1'b0;
      v = 1'b0;
      r = 8'h00;
      case (op)
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         OP_SUB: begin
            r = a - b;
            c = (a >= b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SHL: r = (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
         OP_SHR: r = (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
         default: r = 8'h00;
      endcase
      return {r, r[7], (r == 8'h00), c, v};
   endfunction

   logic [11:0] alu_out;
   always_comb begin
      alu_out      = alu_f(alu_operation, alu_operand1, alu_operand2);
      alu_result   = alu_out[11:4];
      alu_negative = alu_out[3];
      alu_zero     = alu_out[2];
      alu_carry    = alu_out[1];
      alu_overflow = alu_out[0];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic use_imm,
                       input logic [7:0] imm, input logic nowb);
      logic [7:0]  a, b;
      logic [11:0] res;
      @(negedge clk);
      cmd_op = op; cmd_rd = rd; cmd_rs = rs;
      cmd_use_imm = use_imm; cmd_imm = imm; cmd_nowb = nowb;
      cmd_valid = 1'b1;
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      a   = model[rd];
      b   = use_imm ? imm : model[rs];
      res = alu_f(op, a, b);
      sb.push_back('{data: res[11:4], flags: res[3:0]});
      if (!nowb) model[rd] = res[11:4];
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("exec_alu_op", 32'(alu_operation), 32'(op));
      chk("exec_alu_opnd1", 32'(alu_operand1), 32'(a));
      chk("exec_alu_opnd2", 32'(alu_operand2), 32'(b));
      @(posedge clk);
      #1;
      chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
   endtask

   // Called in RESP right after rsp_valid rose.
   task automatic take(input int hold);
      exp_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL sb_empty observed=%0d expected=1", sb.size());
         return;
      end
      e = sb.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         chk("dbg_reg", 32'(dbg_data), 32'(model[i]));
      end
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         cmd_op = OP_ADD; cmd_rd = 2'd1; cmd_use_imm = 1'b1;
         cmd_imm = 8'h55; cmd_nowb = 1'b0;
         cmd_valid = 1'b1;
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rsp_data", 32'(rsp_data), 32'(e.data));
         chk("hold_rsp_flags", 32'(rsp_flags), 32'(e.flags));
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
      chk({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_operation), 32'd0);
      chk({tag, "_alu_opnd1"}, 32'(alu_operand1), 32'd0);
      chk({tag, "_alu_opnd2"}, 32'(alu_operand2), 32'd0);
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         chk({tag, "_reg"}, 32'(dbg_data), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = 4'd0; cmd_rd = 2'd0; cmd_rs = 2'd0; cmd_use_imm = 1'b0;
      cmd_imm = 8'd0; cmd_nowb = 1'b0; dbg_addr = 2'd0;
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state("reset");

      // 1: OR R1 <- 0 | 0x7F
      send(OP_OR, 2'd1, 2'd0, 1'b1, 8'h7F, 1'b0);
      take(0);
      chk("t1_data", 32'(rsp_data), 32'h7F);
      chk("t1_flags", 32'(rsp_flags), 32'b0000);

      // 2: ADD R1 + 1 -> 0x80, signed overflow
      send(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h01, 1'b0);
      take(0);
      chk("t2_data", 32'(rsp_data), 32'h80);
      chk("t2_flags", 32'(rsp_flags), 32'b1001);
      dbg_addr = 2'd1; #1;
      chk("t2_r1", 32'(dbg_data), 32'h80);

      // 3: compare R1 with 0x80, no writeback
      send(OP_SUB, 2'd1, 2'd0, 1'b1, 8'h80, 1'b1);
      take(0);
      chk("t3_data", 32'(rsp_data), 32'h00);
      chk("t3_flags", 32'(rsp_flags), 32'b0110);
      dbg_addr = 2'd1; #1;
      chk("t3_r1", 32'(dbg_data), 32'h80);

      // 4: R2 = 3, shift by R3 (=0), shift by 9
      send(OP_OR, 2'd2, 2'd0, 1'b1, 8'h03, 1'b0);
      take(0);
      send(OP_SHL, 2'd2, 2'd3, 1'b0, 8'hFF, 1'b0);
      take(0);
      dbg_addr = 2'd2; #1;
      chk("t4_r2_mid", 32'(dbg_data), 32'h03);
      send(OP_SHL, 2'd2, 2'd0, 1'b1, 8'h09, 1'b0);
      take(0);
      chk("t4_flags", 32'(rsp_flags), 32'b0100);
      dbg_addr = 2'd2; #1;
      chk("t4_r2", 32'(dbg_data), 32'h00);

      // 5: response back-pressure with ignored command pulses; rd = rs too
      send(OP_XOR, 2'd3, 2'd0, 1'b1, 8'hA5, 1'b0);
      take(5);
      send(OP_ADD, 2'd3, 2'd3, 1'b0, 8'h00, 1'b0);
      take(1);
      dbg_addr = 2'd3; #1;
      chk("t5_r3", 32'(dbg_data), 32'h4A);

      // 6: reset during EXEC drops the command
      @(negedge clk);
      cmd_op = OP_ADD; cmd_rd = 2'd1; cmd_use_imm = 1'b1;
      cmd_imm = 8'h01; cmd_nowb = 1'b0; cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("t6_in_exec", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
      check_reset_state("t6");
      @(posedge clk);
      #1;
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);

      // Register file usable again after reset
      send(OP_OR, 2'd0, 2'd0, 1'b1, 8'h3C, 1'b0);
      take(0);
      chk("t7_data", 32'(rsp_data), 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
